// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcode map, immediate-type codes,
// decode-slot entry layout and its reset value.
package rv32i_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_U    = 3'd0,
        IMM_J    = 3'd1,
        IMM_I    = 3'd2,
        IMM_S    = 3'd3,
        IMM_B    = 3'd4,
        IMM_NONE = 3'd7
    } imm_type_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } id_state_e;

    typedef struct packed {
        imm_type_e imm_type;
        logic      illegal;
    } id_dec_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] imm;
        imm_type_e   imm_type;
        logic        illegal;
    } id_entry_t;

    localparam id_entry_t ID_ENTRY_RST = '{
        inst:     32'd0,
        pc:       32'd0,
        imm:      32'd0,
        imm_type: IMM_NONE,
        illegal:  1'b0
    };

endpackage

// File: rtl/Imm_generator.sv
// RV32I immediate generator: assembles the sign-extended immediate for the
// given immediate type; produces zero for IMM_NONE.
module Imm_generator
    import rv32i_pkg::*;
(
    input  logic [31:7] inst_i,
    input  imm_type_e   imm_type_i,
    output logic [31:0] imm_o
);

    // Bit-field assembly per immediate format
    always_comb begin
        imm_o = 32'd0;
        case (imm_type_i)
            IMM_U:   imm_o = {inst_i[31:12], 12'd0};
            IMM_J:   imm_o = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
            IMM_I:   imm_o = {{21{inst_i[31]}}, inst_i[30:20]};
            IMM_S:   imm_o = {{21{inst_i[31]}}, inst_i[30:25], inst_i[11:7]};
            IMM_B:   imm_o = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
            default: imm_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/id_decode_ctrl.sv
// RV32I decode-stage controller with valid/ready handshake and flush.
// Optional two-entry skid buffer with registered if_ready: define ID_SKID_EN.
module id_decode_ctrl
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_inst,
    input  logic [XLEN-1:0] if_pc,
    input  logic            flush,
    output logic            id_valid,
    input  logic            ex_ready,
    output logic [31:0]     id_inst,
    output logic [XLEN-1:0] id_pc,
    output logic [2:0]      id_imm_type,
    output logic [XLEN-1:0] id_imm,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic [4:0]      id_rd,
    output logic            id_illegal
);

    function automatic id_dec_t classify(input logic [6:0] opc);
        id_dec_t d;
        d.imm_type = IMM_NONE;
        d.illegal  = 1'b0;
        case (opc)
            OPC_LUI, OPC_AUIPC:                 d.imm_type = IMM_U;
            OPC_JAL:                            d.imm_type = IMM_J;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM,
            OPC_MISC_MEM, OPC_SYSTEM:           d.imm_type = IMM_I;
            OPC_STORE:                          d.imm_type = IMM_S;
            OPC_BRANCH:                         d.imm_type = IMM_B;
            OPC_OP:                             d.imm_type = IMM_NONE;
            default: begin
                d.imm_type = IMM_NONE;
                d.illegal  = 1'b1;
            end
        endcase
        return d;
    endfunction

    id_state_e   state_q, state_d;
    id_entry_t   main_q, main_d;
    id_dec_t     dec_s;
    id_entry_t   in_entry_s;
    logic [31:0] gen_imm_s;
    logic        fetch_s;
    logic        ex_s;

    assign dec_s = classify(if_inst[6:0]);

    Imm_generator u_imm_gen (
        .inst_i     (if_inst[31:7]),
        .imm_type_i (dec_s.imm_type),
        .imm_o      (gen_imm_s)
    );

    // Incoming entry; immediate forced to zero when there is none
    always_comb begin
        in_entry_s.inst     = if_inst;
        in_entry_s.pc       = if_pc;
        in_entry_s.imm_type = dec_s.imm_type;
        in_entry_s.illegal  = dec_s.illegal;
        if (dec_s.imm_type == IMM_NONE) begin
            in_entry_s.imm = 32'd0;
        end else begin
            in_entry_s.imm = gen_imm_s;
        end
    end

    assign id_valid = (state_q != ST_EMPTY);
    assign fetch_s  = if_valid && if_ready;
    assign ex_s     = id_valid && ex_ready;

`ifdef ID_SKID_EN
    id_entry_t skid_q, skid_d;
    logic      if_ready_q;

    // Next state and entry loads for the two-entry buffer
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (fetch_s) begin
                    main_d  = in_entry_s;
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (fetch_s && ex_s) begin
                    main_d = in_entry_s;
                end else if (ex_s) begin
                    state_d = ST_EMPTY;
                end else if (fetch_s) begin
                    skid_d  = in_entry_s;
                    state_d = ST_SKID;
                end else begin
                    state_d = ST_FULL;
                end
            end
            ST_SKID: begin
                if (ex_s) begin
                    main_d  = skid_q;
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_SKID;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush drops everything, including a same-cycle fetch
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end else begin
            state_d = state_d;
        end
    end

    // Skid entry and registered ready (no path from ex_ready)
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_q     <= ID_ENTRY_RST;
            if_ready_q <= 1'b1;
        end else begin
            skid_q     <= skid_d;
            if_ready_q <= (state_d != ST_SKID);
        end
    end

    assign if_ready = if_ready_q;
`else
    // Next state and entry load for the single-register slot
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        case (state_q)
            ST_EMPTY: begin
                if (fetch_s) begin
                    main_d  = in_entry_s;
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (fetch_s && ex_s) begin
                    main_d = in_entry_s;
                end else if (ex_s) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = main_q;
        end else begin
            state_d = state_d;
        end
    end

    assign if_ready = !id_valid || ex_ready;
`endif

    // State and main-entry registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= ID_ENTRY_RST;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

    assign id_inst     = main_q.inst;
    assign id_pc       = main_q.pc;
    assign id_imm      = main_q.imm;
    assign id_imm_type = main_q.imm_type;
    assign id_illegal  = main_q.illegal;
    assign id_rs1      = main_q.inst[19:15];
    assign id_rs2      = main_q.inst[24:20];
    assign id_rd       = main_q.inst[11:7];

endmodule

// File: tb/tb_id_decode_ctrl.sv
// Self-checking bench for id_decode_ctrl: directed test-plan steps followed by
// randomized traffic, compared against a queue-based reference model.
module tb_id_decode_ctrl;

    logic        clk = 1'b0;
    logic        rst, if_valid, if_ready, flush, id_valid, ex_ready, id_illegal;
    logic [31:0] if_inst, if_pc, id_inst, id_pc, id_imm;
    logic [2:0]  id_imm_type;
    logic [4:0]  id_rs1, id_rs2, id_rd;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    ent_t        q[$];
    bit          fresh = 1'b1;
    logic [31:0] pc_ctr = 32'h0000_1000;

    id_decode_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
        .if_inst(if_inst), .if_pc(if_pc), .flush(flush), .id_valid(id_valid),
        .ex_ready(ex_ready), .id_inst(id_inst), .id_pc(id_pc),
        .id_imm_type(id_imm_type), .id_imm(id_imm), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_rd(id_rd), .id_illegal(id_illegal)
    );

    always #5 clk = ~clk;

    // Reference immediate type from the opcode table
    function automatic logic [31:0] ref_type(input logic [31:0] inst);
        logic [6:0] o;
        o = inst[6:0];
        if (o == 7'h37 || o == 7'h17) return 32'd0;
        if (o == 7'h6F) return 32'd1;
        if (o == 7'h67 || o == 7'h03 || o == 7'h13 || o == 7'h0F || o == 7'h73) return 32'd2;
        if (o == 7'h23) return 32'd3;
        if (o == 7'h63) return 32'd4;
        return 32'd7;
    endfunction

    function automatic logic [31:0] ref_illegal(input logic [31:0] inst);
        if (ref_type(inst) == 32'd7 && inst[6:0] != 7'h33) return 32'd1;
        return 32'd0;
    endfunction

    // Reference immediate built with shifts and masks on the whole word
    function automatic logic [31:0] ref_imm(input logic [31:0] inst);
        logic signed [31:0] s;
        case (ref_type(inst))
            32'd0: return inst & 32'hFFFF_F000;
            32'd1: begin
                s = $signed(inst & 32'h8000_0000) >>> 11;
                return s | (inst & 32'h000F_F000) | ((inst >> 9) & 32'h800) | ((inst >> 20) & 32'h7FE);
            end
            32'd2: begin
                s = $signed(inst) >>> 20;
                return s;
            end
            32'd3: begin
                s = $signed(inst & 32'hFE00_0000) >>> 20;
                return s | ((inst >> 7) & 32'h1F);
            end
            32'd4: begin
                s = $signed(inst & 32'h8000_0000) >>> 19;
                return s | ((inst << 4) & 32'h800) | ((inst >> 20) & 32'h7E0) | ((inst >> 7) & 32'h1E);
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic exp_ready(input logic exr);
`ifdef ID_SKID_EN
        return q.size() < 2;
`else
        return (q.size() == 0) || exr;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("id_valid", {31'd0, id_valid}, {31'd0, q.size() > 0});
        if (q.size() > 0) begin
            chk("id_inst", id_inst, q[0].inst);
            chk("id_pc", id_pc, q[0].pc);
            chk("id_imm", id_imm, ref_imm(q[0].inst));
            chk("id_imm_type", {29'd0, id_imm_type}, ref_type(q[0].inst));
            chk("id_illegal", {31'd0, id_illegal}, ref_illegal(q[0].inst));
            chk("id_rs1", {27'd0, id_rs1}, (q[0].inst >> 15) & 32'h1F);
            chk("id_rs2", {27'd0, id_rs2}, (q[0].inst >> 20) & 32'h1F);
            chk("id_rd", {27'd0, id_rd}, (q[0].inst >> 7) & 32'h1F);
        end else if (fresh) begin
            chk("rst_inst", id_inst, 32'd0);
            chk("rst_pc", id_pc, 32'd0);
            chk("rst_imm", id_imm, 32'd0);
            chk("rst_type", {29'd0, id_imm_type}, 32'd7);
            chk("rst_illegal", {31'd0, id_illegal}, 32'd0);
            chk("rst_regs", {17'd0, id_rs1, id_rs2, id_rd}, 32'd0);
        end
    endtask

    // One clock: drive, check ready, update model at the edge, check outputs
    task automatic step(input logic v, input logic [31:0] inst, input logic fl,
                        input logic exr, input logic r);
        logic fetch, ex;
        @(negedge clk);
        if_valid = v; if_inst = inst; if_pc = pc_ctr;
        flush = fl; ex_ready = exr; rst = r;
        #1;
        if (!r) chk("if_ready", {31'd0, if_ready}, {31'd0, exp_ready(exr)});
        fetch = v && exp_ready(exr);
        ex    = (q.size() > 0) && exr;
        @(posedge clk);
        if (r) begin
            q.delete();
            fresh = 1'b1;
        end else if (fl) begin
            q.delete();
        end else begin
            if (ex) void'(q.pop_front());
            if (fetch) begin
                q.push_back('{inst: inst, pc: pc_ctr});
                fresh = 1'b0;
            end
        end
        pc_ctr = pc_ctr + 32'd4;
        #1;
        check_outputs();
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [6:0]  opcs [12];
        opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h0F, 7'h73,
                 7'h23, 7'h63, 7'h33, 7'h7F};
        r = $urandom;
        if ($urandom_range(0, 9) != 0) r[6:0] = opcs[$urandom_range(0, 11)];
        return r;
    endfunction

    initial begin
        rst = 1'b1; if_valid = 1'b0; if_inst = 32'd0; if_pc = 32'd0;
        flush = 1'b0; ex_ready = 1'b1;

        // Reset and reset-state values
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

        // addi x1,x0,-1
        step(1'b1, 32'hFFF0_0093, 1'b0, 1'b1, 1'b0);
        chk("addi_imm", id_imm, 32'hFFFF_FFFF);
        chk("addi_type", {29'd0, id_imm_type}, 32'd2);
        chk("addi_rd", {27'd0, id_rd}, 32'd1);

        // Back-to-back LUI, beq, sw
        step(1'b1, 32'h1234_52B7, 1'b0, 1'b1, 1'b0);
        chk("lui_imm", id_imm, 32'h1234_5000);
        step(1'b1, 32'hFE00_0EE3, 1'b0, 1'b1, 1'b0);
        chk("beq_imm", id_imm, 32'hFFFF_FFFC);
        chk("beq_type", {29'd0, id_imm_type}, 32'd4);
        step(1'b1, 32'h0020_A423, 1'b0, 1'b1, 1'b0);
        chk("sw_imm", id_imm, 32'd8);
        chk("sw_type", {29'd0, id_imm_type}, 32'd3);
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

        // Stall execute for 3 cycles with fetch streaming, then release
        step(1'b1, rand_inst(), 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, rand_inst(), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, rand_inst(), 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

        // Flush while full (skid when present) with a simultaneous fetch
        step(1'b1, rand_inst(), 1'b0, 1'b0, 1'b0);
        step(1'b1, rand_inst(), 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0050_0113, 1'b1, 1'b0, 1'b0);
        chk("flush_valid", {31'd0, id_valid}, 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);

        // R-type and illegal opcode
        step(1'b1, 32'h0000_0033, 1'b0, 1'b1, 1'b0);
        chk("add_illegal", {31'd0, id_illegal}, 32'd0);
        chk("add_imm", id_imm, 32'd0);
        step(1'b1, 32'h0000_007F, 1'b0, 1'b1, 1'b0);
        chk("ill_illegal", {31'd0, id_illegal}, 32'd1);
        chk("ill_type", {29'd0, id_imm_type}, 32'd7);

        // Reset while full and stalled
        step(1'b1, rand_inst(), 1'b0, 1'b0, 1'b0);
        step(1'b1, rand_inst(), 1'b0, 1'b0, 1'b1);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, rand_inst(), $urandom_range(0, 29) == 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
